// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// word-wide memory bus. Lines are filled and written back one word beat at a time.
module dcache #(
    parameter int NLINES         = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        cpu_byte,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        dhit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OFFW = $clog2(WORDS_PER_LINE);
    localparam int IDXW = $clog2(NLINES);
    localparam int TAGW = 32 - 2 - OFFW - IDXW;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] REFILL    = 2'd2;

    localparam logic [OFFW-1:0] BEAT0     = '0;
    localparam logic [OFFW-1:0] LAST_BEAT = OFFW'(WORDS_PER_LINE - 1);

    logic [1:0]        state;
    logic [OFFW-1:0]   beat;
    logic [NLINES-1:0] valid;
    logic [NLINES-1:0] dirty;
    logic [TAGW-1:0]   tag_arr  [NLINES];
    logic [31:0]       data_arr [NLINES][WORDS_PER_LINE];

    logic [TAGW-1:0] addr_tag;
    logic [IDXW-1:0] idx;
    logic [OFFW-1:0] word;
    logic [1:0]      byte_off;
    logic            access;
    logic            hit;
    logic            idle;
    logic            write_hit;
    logic            ack;
    logic            last;
    logic [OFFW-1:0] next_beat;
    logic [31:0]     store_word;

    assign addr_tag  = cpu_addr[31 -: TAGW];
    assign idx       = cpu_addr[2+OFFW +: IDXW];
    assign word      = cpu_addr[2 +: OFFW];
    assign byte_off  = cpu_addr[1:0];

    assign access    = cpu_rd | cpu_wr;
    assign hit       = valid[idx] && (tag_arr[idx] == addr_tag);
    assign idle      = (state == IDLE);
    assign dhit      = !access || (idle && hit);
    assign cpu_rdata = (idle && hit) ? data_arr[idx][word] : '0;
    assign write_hit = idle && hit && cpu_wr;

    // Acks are only meaningful against an outstanding request.
    assign ack       = mem_req && mem_ack;
    assign last      = (beat == LAST_BEAT);
    assign next_beat = beat + 1'b1;

    // Byte stores are big-endian: byte offset 0 lands in the most significant byte.
    always_comb begin
        store_word = cpu_wdata;
        if (cpu_byte) begin
            store_word = data_arr[idx][word];
            case (byte_off)
                2'd0:    store_word[31:24] = cpu_wdata[7:0];
                2'd1:    store_word[23:16] = cpu_wdata[7:0];
                2'd2:    store_word[15:8]  = cpu_wdata[7:0];
                default: store_word[7:0]   = cpu_wdata[7:0];
            endcase
        end
    end

    // Tags and data are not reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            data_arr[idx][word] <= store_word;
        end
        if (state == REFILL && ack) begin
            data_arr[idx][beat] <= mem_rdata;
            if (last) begin
                tag_arr[idx] <= addr_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat      <= '0;
            valid     <= '0;
            dirty     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                    if (access && !hit) begin
                        beat    <= '0;
                        mem_req <= 1'b1;
                        if (valid[idx] && dirty[idx]) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_arr[idx], idx, BEAT0, 2'b00};
                            mem_wdata <= data_arr[idx][0];
                        end else begin
                            state    <= REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {addr_tag, idx, BEAT0, 2'b00};
                        end
                    end
                end
                WRITEBACK: begin
                    if (ack) begin
                        if (last) begin
                            beat     <= '0;
                            state    <= REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {addr_tag, idx, BEAT0, 2'b00};
                        end else begin
                            beat      <= next_beat;
                            mem_addr  <= {tag_arr[idx], idx, next_beat, 2'b00};
                            mem_wdata <= data_arr[idx][next_beat];
                        end
                    end
                end
                REFILL: begin
                    if (ack) begin
                        if (last) begin
                            beat       <= '0;
                            state      <= IDLE;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            valid[idx] <= 1'b1;
                            dirty[idx] <= 1'b0;
                        end else begin
                            beat     <= next_beat;
                            mem_addr <= {addr_tag, idx, next_beat, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized traffic checked
// against an architectural memory image and a line-state model of the cache.
module tb_dcache;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr, cpu_byte;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dhit;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    dcache #(.NLINES(4), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dhit(dhit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;
    beat_t beats_q[$];

    // amem: memory as the CPU sees it; bmem: the backing store behind the bus.
    logic [31:0] amem [logic [31:0]];
    logic [31:0] bmem [logic [31:0]];
    int ack_mode = 0;  // 0: ack every request, 1: hold ack low, 2: random acks with noise

    logic        m_valid [4];
    logic        m_dirty [4];
    logic [25:0] m_tag   [4];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] rd_arch(logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return amem.exists(wa) ? amem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] rd_back(logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return bmem.exists(wa) ? bmem[wa] : init_word(wa);
    endfunction

    function automatic void arch_store(logic [31:0] a, logic [31:0] wd, logic bt);
        logic [31:0] wa, w;
        int sh;
        wa = {a[31:2], 2'b00};
        w  = rd_arch(wa);
        if (bt) begin
            sh = (3 - int'(a[1:0])) * 8;
            w  = (w & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
        end else begin
            w = wd;
        end
        amem[wa] = w;
    endfunction

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mem_ack = 1'b0;
        end else begin
            case (ack_mode)
                0:       mem_ack = mem_req;
                1:       mem_ack = 1'b0;
                default: mem_ack = mem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            endcase
        end
        mem_rdata = rd_back(mem_addr);
    end

    always @(posedge clk) begin
        if (reset === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
            beats_q.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) bmem[{mem_addr[31:2], 2'b00}] = mem_wdata;
        end
    end

    // Starts just after a rising edge; returns just after the edge that retires the access.
    task automatic access(input logic rd, input logic wr, input logic bt, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata, output int cyc);
        beats_q.delete();
        cpu_rd = rd; cpu_wr = wr; cpu_byte = bt; cpu_addr = a; cpu_wdata = wd;
        cyc = 0;
        @(negedge clk);
        while (dhit !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        rdata = cpu_rdata;
        if (cyc >= 400) begin
            tests++; fails++;
            $display("FAIL access_timeout addr=%h: dhit never rose within %0d cycles", a, cyc);
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h, required all zero",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        tests++;
        if (dhit !== 1'b1 || cpu_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_idle: dhit=%b rdata=%h, required dhit=1 rdata=0", dhit, cpu_rdata);
        end
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (dhit !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: dhit=%b req=%b, required dhit=0 req=0", dhit, mem_req);
        end
        cpu_rd = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_refill_clean();
        logic [31:0] rdata;
        int cyc;
        access(1, 0, 0, 32'h40, 32'h0, rdata, cyc);
        tests++;
        if (cyc != 5) begin
            fails++;
            $display("FAIL refill_latency: %0d stall cycles, required 5", cyc);
        end
        tests++;
        if (beats_q.size() != 4) begin
            fails++;
            $display("FAIL refill_beats: %0d beats, required 4", beats_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (beats_q[i].we !== 1'b0 || beats_q[i].addr !== 32'h40 + 32'(4 * i)) begin
                    fails++;
                    $display("FAIL refill_beat%0d: we=%b addr=%h, required we=0 addr=%h",
                             i, beats_q[i].we, beats_q[i].addr, 32'h40 + 32'(4 * i));
                end
            end
        end
        tests++;
        if (rdata !== rd_arch(32'h40)) begin
            fails++;
            $display("FAIL refill_data: rdata=%h, required %h", rdata, rd_arch(32'h40));
        end
    endtask

    task automatic test_hit();
        logic [31:0] rdata;
        int cyc;
        access(1, 0, 0, 32'h48, 32'h0, rdata, cyc);
        tests++;
        if (cyc != 0 || beats_q.size() != 0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL hit_latency: cyc=%0d beats=%0d req=%b, required 0/0/0", cyc, beats_q.size(), mem_req);
        end
        tests++;
        if (rdata !== rd_arch(32'h48)) begin
            fails++;
            $display("FAIL hit_data: rdata=%h, required %h", rdata, rd_arch(32'h48));
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rdata, orig, expv;
        int cyc;
        orig = rd_arch(32'h40);
        expv = {orig[31:24], 8'hAB, orig[15:0]};
        access(0, 1, 1, 32'h41, 32'h1234_56AB, rdata, cyc);
        arch_store(32'h41, 32'h1234_56AB, 1'b1);
        tests++;
        if (cyc != 0 || beats_q.size() != 0) begin
            fails++;
            $display("FAIL byte_store_hit: cyc=%0d beats=%0d, required 0/0", cyc, beats_q.size());
        end
        access(1, 0, 0, 32'h40, 32'h0, rdata, cyc);
        tests++;
        if (rdata !== expv || cyc != 0) begin
            fails++;
            $display("FAIL byte_store_data: rdata=%h cyc=%0d, required %h cyc=0", rdata, cyc, expv);
        end
    endtask

    task automatic test_writeback();
        logic [31:0] rdata, ea, ed, modified;
        int cyc;
        modified = rd_arch(32'h40);
        access(1, 0, 0, 32'h80, 32'h0, rdata, cyc);
        tests++;
        if (cyc != 9) begin
            fails++;
            $display("FAIL wb_latency: %0d stall cycles, required 9", cyc);
        end
        tests++;
        if (beats_q.size() != 8) begin
            fails++;
            $display("FAIL wb_beats: %0d beats, required 8", beats_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                ea = (i < 4) ? 32'h40 + 32'(4 * i) : 32'h80 + 32'(4 * (i - 4));
                ed = (i < 4) ? rd_arch(ea) : beats_q[i].wdata;
                tests++;
                if (beats_q[i].we !== (i < 4) || beats_q[i].addr !== ea || beats_q[i].wdata !== ed) begin
                    fails++;
                    $display("FAIL wb_beat%0d: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             i, beats_q[i].we, beats_q[i].addr, beats_q[i].wdata, (i < 4), ea, ed);
                end
            end
            tests++;
            if (beats_q[0].wdata !== modified) begin
                fails++;
                $display("FAIL wb_modified: wdata=%h, required %h", beats_q[0].wdata, modified);
            end
        end
        tests++;
        if (rdata !== rd_arch(32'h80)) begin
            fails++;
            $display("FAIL wb_data: rdata=%h, required %h", rdata, rd_arch(32'h80));
        end
    endtask

    task automatic test_ack_stall();
        logic [31:0] rdata, exp_wd;
        int cyc;
        access(0, 1, 0, 32'h84, 32'hC0DE_0084, rdata, cyc);
        arch_store(32'h84, 32'hC0DE_0084, 1'b0);
        exp_wd = rd_arch(32'h80);
        ack_mode = 1;
        beats_q.delete();
        cpu_rd = 1'b1; cpu_addr = 32'hC0;
        @(negedge clk);
        @(negedge clk);
        repeat (6) begin
            tests++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== exp_wd ||
                dhit !== 1'b0 || cpu_rdata !== 32'h0) begin
                fails++;
                $display("FAIL stall_hold: req=%b we=%b addr=%h wdata=%h dhit=%b rdata=%h, required 1/1/00000080/%h/0/0",
                         mem_req, mem_we, mem_addr, mem_wdata, dhit, cpu_rdata, exp_wd);
            end
            @(negedge clk);
        end
        ack_mode = 0;
        cyc = 0;
        while (dhit !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        rdata = cpu_rdata;
        tests++;
        if (cyc >= 100 || beats_q.size() != 8) begin
            fails++;
            $display("FAIL stall_complete: cyc=%0d beats=%0d, required <100 and 8", cyc, beats_q.size());
        end else begin
            tests++;
            if (beats_q[1].wdata !== 32'hC0DE_0084 || beats_q[4].addr !== 32'hC0) begin
                fails++;
                $display("FAIL stall_beats: wb1 wdata=%h rf0 addr=%h, required c0de0084/000000c0",
                         beats_q[1].wdata, beats_q[4].addr);
            end
        end
        tests++;
        if (rdata !== rd_arch(32'hC0)) begin
            fails++;
            $display("FAIL stall_data: rdata=%h, required %h", rdata, rd_arch(32'hC0));
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rdata;
        int cyc;
        ack_mode = 0;
        beats_q.delete();
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        cyc = 0;
        while (beats_q.size() < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (cyc >= 50 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || dhit !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: cyc=%0d req=%b we=%b addr=%h dhit=%b, required req=0 we=0 addr=0 dhit=0",
                     cyc, mem_req, mem_we, mem_addr, dhit);
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        reset = 1'b1;
        amem = bmem;
        @(posedge clk); #1;
        access(1, 0, 0, 32'h40, 32'h0, rdata, cyc);
        tests++;
        if (cyc != 5 || beats_q.size() != 4) begin
            fails++;
            $display("FAIL reset_refetch: cyc=%0d beats=%0d, required 5/4", cyc, beats_q.size());
        end else begin
            tests++;
            if (beats_q[0].addr !== 32'h40 || beats_q[3].addr !== 32'h4C || beats_q[0].we !== 1'b0) begin
                fails++;
                $display("FAIL reset_refetch_order: first=%h last=%h we=%b, required 00000040/0000004c/0",
                         beats_q[0].addr, beats_q[3].addr, beats_q[0].we);
            end
        end
        tests++;
        if (rdata !== rd_arch(32'h40)) begin
            fails++;
            $display("FAIL reset_refetch_data: rdata=%h, required %h", rdata, rd_arch(32'h40));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rdata, ea, ed;
        logic [1:0]  idx;
        logic [25:0] tg;
        logic        rd, wr, bt, hit;
        int          op, cyc, nwb, nb;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        amem = bmem;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
        end
        ack_mode = 2;
        for (int n = 0; n < 200; n++) begin
            a  = 32'($urandom_range(0, 255)) | (($urandom_range(0, 3) == 0) ? 32'h0001_0000 : 32'h0);
            wd = $urandom;
            op = $urandom_range(0, 4);
            rd = (op <= 1) || (op == 4);
            wr = (op >= 2);
            bt = (op == 3) || (op == 4 && $urandom_range(0, 1) == 1);
            idx = a[5:4];
            tg  = a[31:6];
            hit = m_valid[idx] && (m_tag[idx] == tg);
            nwb = (!hit && m_valid[idx] && m_dirty[idx]) ? 4 : 0;
            nb  = hit ? 0 : nwb + 4;
            access(rd, wr, bt, a, wd, rdata, cyc);
            tests++;
            if ((cyc == 0) !== hit) begin
                fails++;
                $display("FAIL rand_hit n=%0d addr=%h: stall cycles=%0d, required hit=%b", n, a, cyc, hit);
            end
            tests++;
            if (beats_q.size() != nb) begin
                fails++;
                $display("FAIL rand_beats n=%0d addr=%h: %0d beats, required %0d", n, a, beats_q.size(), nb);
            end else begin
                for (int i = 0; i < nb; i++) begin
                    ea = (i < nwb) ? {m_tag[idx], idx, 2'(i), 2'b00} : {tg, idx, 2'(i - nwb), 2'b00};
                    ed = (i < nwb) ? rd_arch(ea) : beats_q[i].wdata;
                    tests++;
                    if (beats_q[i].we !== (i < nwb) || beats_q[i].addr !== ea || beats_q[i].wdata !== ed) begin
                        fails++;
                        $display("FAIL rand_beat n=%0d i=%0d: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 n, i, beats_q[i].we, beats_q[i].addr, beats_q[i].wdata, (i < nwb), ea, ed);
                    end
                end
            end
            if (!wr) begin
                tests++;
                if (rdata !== rd_arch(a)) begin
                    fails++;
                    $display("FAIL rand_load n=%0d addr=%h: rdata=%h, required %h", n, a, rdata, rd_arch(a));
                end
            end
            if (!hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_dirty[idx] = 1'b0;
            end
            if (wr) begin
                arch_store(a, wd, bt);
                m_dirty[idx] = 1'b1;
            end
        end
        ack_mode = 0;
    endtask

    initial begin
        test_reset();
        test_refill_clean();
        test_hit();
        test_byte_store();
        test_writeback();
        test_ack_stall();
        test_reset_mid_refill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
